adpcm_stream_ctrl: RTL and testbench

Sequencing controller for the CIC/ADPCM compressor datapath. Generates the compressor's decimation clock and block enable, runs a start/warm-up/run/drain state machine, and packs the 4-bit ADPCM codes into bytes. Bytes are buffered in a small FIFO and presented on a valid/ready stream. Sits between the top-level pin wrapper and the compressor instance; all logic runs on the single fast clock.

---
 rtl/adpcm_stream_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_adpcm_stream_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_stream_ctrl.sv
// adpcm_stream_ctrl: decimation clock, session FSM, nibble packer, byte FIFO.
// Define ADPCM_CTRL_OVF_CNT_EN to build the saturating dropped-byte counter.
module adpcm_stream_ctrl #(
  parameter int DECIM          = 64,
  parameter int WARMUP_SAMPLES = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  output logic       cic_slow_clk,
  output logic       cic_block_enable,
  input  logic       cic_out_valid,
  input  logic [3:0] cic_enc_pcm,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] ovf_count
);

  localparam int CW = $clog2(DECIM);
  localparam int WW = $clog2(WARMUP_SAMPLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic          valid_q;
  logic          valid_p;
  logic [3:0]    pcm_q;
  logic [3:0]    low;
  logic          half;
  logic          pad_pend;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;

  logic       running;
  logic       wrap;
  logic       sess_start;
  logic       evt;
  logic       capture;
  logic       pad_push;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       full;
  logic       accept;
  logic       drop;

  assign running    = (state == S_WARMUP) || (state == S_RUN);
  assign wrap       = running && (cnt == CW'(DECIM - 1));
  assign sess_start = (state == S_IDLE) && start;
  assign evt        = valid_q && !valid_p;
  assign capture    = (state == S_RUN) && evt && !stop;
  assign pad_push   = (state == S_DRAIN) && pad_pend;
  assign push       = (capture && half) || pad_push;
  assign push_data  = pad_push ? {4'h0, low} : {pcm_q, low};
  assign pop        = m_valid && m_ready && ena;
  assign full       = (fill == (AW+1)'(FIFO_DEPTH));
  assign accept     = push && (!full || pop);
  assign drop       = push && full && !pop;

  assign cic_slow_clk     = (cnt < CW'(DECIM / 2));
  assign cic_block_enable = running;
  assign busy             = (state != S_IDLE);
  assign m_valid          = (fill != '0);
  assign m_data           = m_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (ena) begin
      unique case (state)
        S_IDLE:   if (start) state <= S_WARMUP;
        S_WARMUP: begin
          if (stop)
            state <= S_IDLE;
          else if (wrap && wcnt == WW'(WARMUP_SAMPLES - 1))
            state <= S_RUN;
        end
        S_RUN:    if (stop) state <= S_DRAIN;
        S_DRAIN:  if (fill == '0 && !pad_pend) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Divider and warm-up counter rest at zero outside the active states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wcnt <= '0;
    end else if (ena) begin
      if (!running || stop || wrap) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (state != S_WARMUP) wcnt <= '0;
      else if (wrap) wcnt <= wcnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      valid_p  <= 1'b0;
      pcm_q    <= 4'h0;
      low      <= 4'h0;
      half     <= 1'b0;
      pad_pend <= 1'b0;
    end else if (ena) begin
      valid_q <= cic_out_valid;
      valid_p <= valid_q;
      pcm_q   <= cic_enc_pcm;
      if (sess_start) begin
        low      <= 4'h0;
        half     <= 1'b0;
        pad_pend <= 1'b0;
      end else if (state == S_RUN && stop) begin
        pad_pend <= half;
      end else if (pad_push) begin
        pad_pend <= 1'b0;
        half     <= 1'b0;
      end else if (capture) begin
        if (!half) low <= pcm_q;
        half <= !half;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ena && accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      if (sess_start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fill     <= '0;
        overflow <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (drop) overflow <= 1'b1;
        unique case ({accept, pop})
          2'b10:   fill <= fill + (AW+1)'(1);
          2'b01:   fill <= fill - (AW+1)'(1);
          default: fill <= fill;
        endcase
      end
    end
  end

`ifdef ADPCM_CTRL_OVF_CNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'h00;
    end else if (ena) begin
      if (sess_start) ovf_cnt <= 8'h00;
      else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_adpcm_stream_ctrl.sv
// tb_adpcm_stream_ctrl: directed bench for the ADPCM stream controller.
// DECIM=4, WARMUP_SAMPLES=2, FIFO_DEPTH=4.
module tb_adpcm_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       stop;
  logic       cic_slow_clk;
  logic       cic_block_enable;
  logic       cic_out_valid;
  logic [3:0] cic_enc_pcm;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       overflow;
  logic [7:0] ovf_count;

`ifdef ADPCM_CTRL_OVF_CNT_EN
  localparam logic [7:0] OVF_EXP = 8'd2;
`else
  localparam logic [7:0] OVF_EXP = 8'd0;
`endif

  int checks = 0;
  int errors = 0;
  int bad;
  logic [7:0] got[$];

  adpcm_stream_ctrl #(
    .DECIM(4),
    .WARMUP_SAMPLES(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .stop(stop),
    .cic_slow_clk(cic_slow_clk),
    .cic_block_enable(cic_block_enable),
    .cic_out_valid(cic_out_valid),
    .cic_enc_pcm(cic_enc_pcm),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy),
    .overflow(overflow),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && ena && m_valid && m_ready) got.push_back(m_data);
  end

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] byte_at(int i);
    if (i < got.size()) return {24'h0, got[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] code);
    cic_enc_pcm = code;
    cic_out_valid = 1'b1;
    tick;
    cic_out_valid = 1'b0;
    tick;
  endtask

  task automatic finish_session(string tag);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    for (int i = 0; i < 50 && busy; i++) tick;
    check(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cic_out_valid = 1'b0;
    cic_enc_pcm = 4'h0;
    m_ready = 1'b0;
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_cbe", cic_block_enable, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_slow", cic_slow_clk, 1);
    check("rst_ovf", overflow, 0);
    check("rst_ovfcnt", ovf_count, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      tick;
      if (busy || cic_block_enable || m_valid || !cic_slow_clk) bad++;
    end
    check("idle_100", bad, 0);

    // Session 1: warm-up edges discarded, then one packed byte.
    m_ready = 1'b1;
    got.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cbe", cic_block_enable, 1);
    check("start_slow", cic_slow_clk, 1);
    tick;
    check("slow_t1", cic_slow_clk, 1);
    tick;
    check("slow_t2", cic_slow_clk, 0);
    pulse(4'hF);
    pulse(4'hE);
    repeat (3) tick;
    pulse(4'h3);
    pulse(4'hA);
    check("a3_valid", m_valid, 1);
    check("a3_data", m_data, 8'hA3);
    repeat (4) tick;
    check("a3_count", got.size(), 1);
    check("a3_byte", byte_at(0), 8'hA3);

    // Odd code count: pad byte pushed on stop.
    got.delete();
    pulse(4'h1);
    pulse(4'h2);
    pulse(4'h3);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check("stop_cbe", cic_block_enable, 0);
    check("stop_busy", busy, 1);
    for (int i = 0; i < 50 && busy; i++) tick;
    check("drain_idle", busy, 0);
    check("pad_count", got.size(), 2);
    check("pad_b0", byte_at(0), 8'h21);
    check("pad_b1", byte_at(1), 8'h03);

    // Overflow: six bytes into a 4-deep FIFO with no consumer.
    got.delete();
    m_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    for (int i = 0; i < 6; i++) begin
      pulse(4'(i));
      pulse(4'(i + 8));
    end
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", ovf_count, OVF_EXP);
    check("ovf_valid", m_valid, 1);
    check("ovf_head", m_data, 8'h80);
    check("ovf_nopop", got.size(), 0);

    // Full FIFO: push and pop on the same edge.
    pulse(4'hE);
    cic_enc_pcm = 4'h7;
    cic_out_valid = 1'b1;
    tick;
    cic_out_valid = 1'b0;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    check("fp_ovfcnt", ovf_count, OVF_EXP);
    check("fp_ovf", overflow, 1);
    check("fp_head", m_data, 8'h91);
    check("fp_popped", got.size(), 1);
    m_ready = 1'b1;
    repeat (6) tick;
    check("fp_count", got.size(), 5);
    check("fp_b0", byte_at(0), 8'h80);
    check("fp_b1", byte_at(1), 8'h91);
    check("fp_b2", byte_at(2), 8'hA2);
    check("fp_b3", byte_at(3), 8'hB3);
    check("fp_b4", byte_at(4), 8'h7E);
    check("fp_empty", m_valid, 0);
    finish_session("fp_idle");

    // New session clears overflow; ena hold; reset mid-run.
    got.delete();
    m_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("new_ovf", overflow, 0);
    check("new_ovfcnt", ovf_count, 0);
    repeat (8) tick;
    pulse(4'h1);
    pulse(4'h2);
    pulse(4'h3);
    pulse(4'h4);
    check("two_valid", m_valid, 1);
    check("two_head", m_data, 8'h21);
    ena = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick;
    check("ena_valid", m_valid, 1);
    check("ena_data", m_data, 8'h21);
    check("ena_nopop", got.size(), 0);
    m_ready = 1'b0;
    ena = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rr_busy", busy, 0);
    check("rr_cbe", cic_block_enable, 0);
    check("rr_mvalid", m_valid, 0);
    check("rr_mdata", m_data, 0);
    check("rr_slow", cic_slow_clk, 1);
    tick;
    rst_n = 1'b1;
    tick;

    got.delete();
    m_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("post_empty", m_valid, 0);
    repeat (8) tick;
    check("post_warm_empty", m_valid, 0);
    pulse(4'h5);
    pulse(4'h6);
    tick;
    check("post_count", got.size(), 1);
    check("post_byte", byte_at(0), 8'h65);
    finish_session("post_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
